// File: rtl/pulse_transmitter_symbol_sequencer_if.sv
// pulse_transmitter_symbol_sequencer_if: symbol write bus into the sequencer FIFO
//   wr_valid/wr_level/wr_duration : producer -> sequencer symbol write request
//   wr_ready                      : sequencer -> producer, FIFO not full
//   fifo_count                    : sequencer -> producer, entries currently queued
interface pulse_transmitter_symbol_sequencer_if #(
    parameter int DEPTH       = 8,
    parameter int TIMER_WIDTH = 8
) ();
    logic                     wr_valid;
    logic                     wr_level;
    logic [TIMER_WIDTH-1:0]   wr_duration;
    logic                     wr_ready;
    logic [$clog2(DEPTH):0]   fifo_count;
    modport master (output wr_valid, wr_level, wr_duration, input wr_ready, fifo_count);
    modport slave  (input wr_valid, wr_level, wr_duration, output wr_ready, fifo_count);
endinterface

// File: rtl/pulse_transmitter_symbol_sequencer.sv
// pulse_transmitter_symbol_sequencer: queues {level, duration} symbols and plays them out through a countdown timer
//   clk, sys_rst        : clock, asynchronous active-high reset
//   start/stop/flush    : begin playback (IDLE only) / abort to IDLE / empty the FIFO
//   idle_level          : pulse_level while not playing
//   prescaler_cfg       : prescaler select, latched on an accepted start
//   wr                  : symbol write bus (slave side)
//   timer_en/_prescaler/_duration : drive the timer; timer_pulse advances to the next symbol
//   pulse_level         : transmitted waveform level
//   busy                : in LOAD or RUN
//   done                : 1-cycle pulse when playback ends because the queue ran dry
module pulse_transmitter_symbol_sequencer #(
    parameter int  DEPTH           = 8,
    parameter int  PRESCALER_WIDTH = 16,
    parameter int  TIMER_WIDTH     = 8,
    localparam int PW              = $clog2(PRESCALER_WIDTH),
    localparam int AW              = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   sys_rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   flush,
    input  logic                   idle_level,
    input  logic [PW-1:0]          prescaler_cfg,
    pulse_transmitter_symbol_sequencer_if.slave wr,
    output logic                   timer_en,
    output logic [PW-1:0]          timer_prescaler,
    output logic [TIMER_WIDTH-1:0] timer_duration,
    input  logic                   timer_pulse,
    output logic                   pulse_level,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    state_t                 state_q, state_d;
    logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TIMER_WIDTH:0]   mem_q [DEPTH];
    logic [TIMER_WIDTH:0]   head;
    logic [TIMER_WIDTH-1:0] timer_duration_d;
    logic [PW-1:0]          timer_prescaler_d;
    logic                   pulse_level_d, timer_en_d, busy_d, done_d;
    logic                   full, empty, wr_en, avail, pop;
    assign full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty         = wr_ptr_q == rd_ptr_q;
    assign wr.wr_ready   = !full;
    assign wr.fifo_count = wr_ptr_q - rd_ptr_q;
    assign wr_en         = wr.wr_valid && !full && !flush;
    // a flush this cycle makes the queue look empty to the player
    assign avail         = !empty && !flush;
    assign head          = mem_q[rd_ptr_q[AW-1:0]];
    always_comb begin
        wr_ptr_d = flush ? '0 : wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d = flush ? '0 : rd_ptr_q + {{AW{1'b0}}, pop};
    end
    always_comb begin
        state_d           = state_q;
        pulse_level_d     = pulse_level_q_w();
        timer_duration_d  = timer_duration;
        timer_prescaler_d = timer_prescaler;
        done_d            = 1'b0;
        pop               = 1'b0;
        case (state_q)
            IDLE: begin
                pulse_level_d = idle_level;
                if (start && avail) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = RUN;
            RUN: if (timer_pulse) begin
                if (avail) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end else begin
                    pulse_level_d = idle_level;
                    done_d        = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d       = IDLE;
            pulse_level_d = idle_level;
            done_d        = 1'b0;
            pop           = 1'b0;
        end
        if (pop) begin
            pulse_level_d    = head[TIMER_WIDTH];
            timer_duration_d = head[TIMER_WIDTH-1:0];
        end
        if (pop && state_q == IDLE) timer_prescaler_d = prescaler_cfg;
        timer_en_d = state_d == RUN;
        busy_d     = state_d != IDLE;
    end
    function automatic logic pulse_level_q_w();
        return pulse_level;
    endfunction
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            pulse_level     <= 1'b0;
            timer_en        <= 1'b0;
            timer_prescaler <= '0;
            timer_duration  <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            pulse_level     <= pulse_level_d;
            timer_en        <= timer_en_d;
            timer_prescaler <= timer_prescaler_d;
            timer_duration  <= timer_duration_d;
            busy            <= busy_d;
            done            <= done_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {wr.wr_level, wr.wr_duration};
    end
endmodule

// File: tb/tb_pulse_transmitter_symbol_sequencer.sv
// tb_pulse_transmitter_symbol_sequencer: directed bench with a behavioural countdown timer
module tb_pulse_transmitter_symbol_sequencer;
    localparam int PW = 4;
    localparam int TW = 8;
    logic          clk = 1'b0, sys_rst = 1'b1, start = 1'b0, stop = 1'b0, flush = 1'b0, idle_level = 1'b0;
    logic [PW-1:0] prescaler_cfg = '0;
    logic          timer_en, timer_pulse, pulse_level, busy, done;
    logic [PW-1:0] timer_prescaler;
    logic [TW-1:0] timer_duration;
    logic [31:0]   tcnt = '0, tr_lvl, tr_en;
    int            checks = 0, failures = 0, done_cnt;
    pulse_transmitter_symbol_sequencer_if #(.DEPTH(8), .TIMER_WIDTH(TW)) wif ();
    pulse_transmitter_symbol_sequencer #(.DEPTH(8), .PRESCALER_WIDTH(16), .TIMER_WIDTH(TW)) dut (
        .clk(clk), .sys_rst(sys_rst), .start(start), .stop(stop), .flush(flush), .idle_level(idle_level),
        .prescaler_cfg(prescaler_cfg), .wr(wif), .timer_en(timer_en), .timer_prescaler(timer_prescaler),
        .timer_duration(timer_duration), .timer_pulse(timer_pulse), .pulse_level(pulse_level),
        .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    // timer: pulse on the ((d+1)<<p)+1-th cycle of en
    assign timer_pulse = timer_en && (tcnt == ((32'(timer_duration) + 32'd1) << timer_prescaler));
    always @(posedge clk) tcnt <= (!timer_en || timer_pulse) ? 32'd0 : tcnt + 32'd1;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic run(input int n);
        tr_lvl = '0;
        tr_en = '0;
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            start = 1'b0;
            tr_lvl = {tr_lvl[30:0], pulse_level};
            tr_en = {tr_en[30:0], timer_en};
            done_cnt += int'(done);
        end
    endtask
    task automatic wr_sym(input logic l, input logic [TW-1:0] d);
        wif.wr_valid = 1'b1;
        wif.wr_level = l;
        wif.wr_duration = d;
        step();
        wif.wr_valid = 1'b0;
    endtask
    initial begin
        wif.wr_valid = 1'b0;
        wif.wr_level = 1'b0;
        wif.wr_duration = '0;
        step();
        step();
        chk("rst_level", pulse_level, 0);
        chk("rst_en", timer_en, 0);
        chk("rst_presc", timer_prescaler, 0);
        chk("rst_dur", timer_duration, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", wif.fifo_count, 0);
        chk("rst_ready", wif.wr_ready, 1);
        sys_rst = 1'b0;
        idle_level = 1'b1;
        step();
        chk("idle_follow_1", pulse_level, 1);
        idle_level = 1'b0;
        step();
        chk("idle_follow_0", pulse_level, 0);
        wr_sym(1'b1, 8'd3);
        wr_sym(1'b0, 8'd5);
        wr_sym(1'b1, 8'd0);
        chk("t1_count", wif.fifo_count, 3);
        start = 1'b1;
        run(20);
        chk("t1_wave", tr_lvl[19:0], 32'hFC038);
        chk("t1_en", tr_en[19:0], 32'h7DFD8);
        chk("t1_done", done_cnt, 1);
        chk("t1_busy", busy, 0);
        chk("t1_count_end", wif.fifo_count, 0);
        wr_sym(1'b1, 8'd2);
        prescaler_cfg = 4'd2;
        start = 1'b1;
        run(16);
        chk("t2_wave", tr_lvl[15:0], 32'hFFFC);
        chk("t2_en", tr_en[15:0], 32'h7FFC);
        chk("t2_presc", timer_prescaler, 2);
        chk("t2_dur", timer_duration, 2);
        chk("t2_done", done_cnt, 1);
        prescaler_cfg = '0;
        for (int i = 0; i < 8; i++) wr_sym(1'b1, 8'd0);
        chk("t3_full_count", wif.fifo_count, 8);
        chk("t3_full_ready", wif.wr_ready, 0);
        wr_sym(1'b1, 8'd0);
        chk("t3_drop_9th", wif.fifo_count, 8);
        start = 1'b1;
        wif.wr_valid = 1'b1;
        step();
        start = 1'b0;
        wif.wr_valid = 1'b0;
        chk("t3_pop_full_wr", wif.fifo_count, 7);
        chk("t3_ready", wif.wr_ready, 1);
        chk("t3_busy", busy, 1);
        step();
        step();
        wif.wr_valid = 1'b1;
        step();
        wif.wr_valid = 1'b0;
        chk("t3_pop_and_wr", wif.fifo_count, 7);
        stop = 1'b1;
        flush = 1'b1;
        step();
        stop = 1'b0;
        flush = 1'b0;
        chk("t3_stopflush_busy", busy, 0);
        chk("t3_stopflush_count", wif.fifo_count, 0);
        chk("t3_stopflush_en", timer_en, 0);
        wr_sym(1'b0, 8'd1);
        wr_sym(1'b0, 8'd1);
        flush = 1'b1;
        wif.wr_valid = 1'b1;
        step();
        flush = 1'b0;
        wif.wr_valid = 1'b0;
        chk("flush_drops_wr", wif.fifo_count, 0);
        idle_level = 1'b1;
        wr_sym(1'b1, 8'd3);
        wr_sym(1'b0, 8'd5);
        wr_sym(1'b1, 8'd0);
        start = 1'b1;
        run(9);
        chk("t4_mid_sym2", pulse_level, 0);
        chk("t4_count_mid", wif.fifo_count, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_stop_level", pulse_level, 1);
        chk("t4_stop_busy", busy, 0);
        chk("t4_stop_en", timer_en, 0);
        chk("t4_stop_done", done, 0);
        chk("t4_stop_count", wif.fifo_count, 1);
        run(20);
        chk("t4_no_done", done_cnt, 0);
        chk("t4_idle_level", pulse_level, 1);
        idle_level = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        wr_sym(1'b1, 8'd9);
        wr_sym(1'b0, 8'd4);
        start = 1'b1;
        run(4);
        chk("t5_run_en", timer_en, 1);
        chk("t5_run_level", pulse_level, 1);
        chk("t5_run_count", wif.fifo_count, 1);
        #2 sys_rst = 1'b1;
        #1;
        chk("t5_rst_level", pulse_level, 0);
        chk("t5_rst_en", timer_en, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_dur", timer_duration, 0);
        chk("t5_rst_count", wif.fifo_count, 0);
        chk("t5_rst_ready", wif.wr_ready, 1);
        @(negedge clk);
        sys_rst = 1'b0;
        step();
        start = 1'b1;
        run(5);
        chk("t5_empty_start_busy", busy, 0);
        chk("t5_empty_start_en", tr_en[4:0], 0);
        chk("t5_empty_start_done", done_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
